// File: rtl/exp_align_pipe_pkg.sv
// rtl/exp_align_pipe_pkg.sv - shared types and shift saturation helper for FPHUB exponent alignment
// Widths here fix align_res_t; module parameters E/M must match EXP_W/MAN_W.
package fphub_align_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SHW_W = $clog2(MAN_W + 4);

  typedef struct packed {
    logic [EXP_W:0]   dif;
    logic [EXP_W-1:0] e_max;
    logic             swap;
    logic             ex_equal_ey;
    logic [SHW_W-1:0] shift_amt;
  } align_res_t;

  // Shifts beyond mantissa + ILSB + guard + sticky only feed sticky, so clamp at m+3.
  function automatic logic [SHW_W-1:0] sat_shift(input logic [EXP_W:0] dif, input int m);
    logic [EXP_W:0] mag;
    logic [EXP_W:0] lim;
    mag = dif[EXP_W] ? (~dif + 1'b1) : dif;
    lim = (EXP_W + 1)'(m + 3);
    return (mag > lim) ? SHW_W'(lim) : SHW_W'(mag);
  endfunction

endpackage

// File: rtl/exp_align_pipe_if.sv
// rtl/exp_align_pipe_if.sv - input/result handshake bundle of the exponent alignment stage
// slave is the pipe side, master is the producer/consumer side.
interface exp_align_if
  import fphub_align_pkg::*;
#(
  parameter int E   = EXP_W,
  parameter int SHW = SHW_W
);
  logic           in_valid;
  logic           in_ready;
  logic [E-1:0]   Ex;
  logic [E-1:0]   Ey;
  logic           out_valid;
  logic           out_ready;
  logic [E:0]     dif;
  logic [E-1:0]   e_max;
  logic           swap;
  logic           ex_equal_ey;
  logic [SHW-1:0] shift_amt;

  modport slave (
    input  in_valid, Ex, Ey, out_ready,
    output in_ready, out_valid, dif, e_max, swap, ex_equal_ey, shift_amt
  );

  modport master (
    output in_valid, Ex, Ey, out_ready,
    input  in_ready, out_valid, dif, e_max, swap, ex_equal_ey, shift_amt
  );
endinterface

// File: rtl/exp_align_pipe_core.sv
// rtl/exp_align_pipe_core.sv - combinational exponent difference, max, swap and saturated shift
module exp_diff_core
  import fphub_align_pkg::*;
#(
  parameter int E = EXP_W,
  parameter int M = MAN_W
) (
  input  logic [E-1:0] ex_i,
  input  logic [E-1:0] ey_i,
  output align_res_t   res_o
);
  logic [E:0] dif;

  // Zero-extended subtraction: the extra bit is the sign, so it cannot overflow.
  assign dif               = {1'b0, ex_i} - {1'b0, ey_i};
  assign res_o.dif         = dif;
  assign res_o.swap        = dif[E];
  assign res_o.e_max       = dif[E] ? ey_i : ex_i;
  assign res_o.ex_equal_ey = (dif == '0);
  assign res_o.shift_amt   = sat_shift(dif, M);
endmodule

// File: rtl/exp_align_pipe.sv
// rtl/exp_align_pipe.sv - registered exponent alignment stage with valid/ready handshake
// EXP_ALIGN_SKID_EN adds a one-entry skid buffer so in_ready comes straight from a flop.
module exp_align_pipe
  import fphub_align_pkg::*;
#(
  parameter int E = EXP_W,
  parameter int M = MAN_W
) (
  input logic       clk,
  input logic       rst_n,
  exp_align_if.slave bus
);
  align_res_t core_res;
  align_res_t res_q, res_d;
  logic       vld_q, vld_d;
  logic       in_ready;
  logic       in_fire;

  exp_diff_core #(.E(E), .M(M)) u_core (
    .ex_i  (bus.Ex),
    .ey_i  (bus.Ey),
    .res_o (core_res)
  );

  assign in_fire = bus.in_valid && in_ready;

`ifdef EXP_ALIGN_SKID_EN
  align_res_t skid_q, skid_d;
  logic       skid_vld_q, skid_vld_d;

  assign in_ready = !skid_vld_q;

  always_comb begin
    res_d      = res_q;
    vld_d      = vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!vld_q || bus.out_ready) begin
      // A held skid entry is older than anything at the input, so it goes first.
      if (skid_vld_q) begin
        res_d      = skid_q;
        vld_d      = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        res_d = in_fire ? core_res : res_q;
        vld_d = in_fire;
      end
    end else if (in_fire) begin
      skid_d     = core_res;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign in_ready = !vld_q || bus.out_ready;

  always_comb begin
    res_d = res_q;
    vld_d = vld_q;
    if (in_fire) begin
      res_d = core_res;
      vld_d = 1'b1;
    end else if (bus.out_ready) begin
      vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      vld_q <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = vld_q;
  assign bus.dif         = res_q.dif;
  assign bus.e_max       = res_q.e_max;
  assign bus.swap        = res_q.swap;
  assign bus.ex_equal_ey = res_q.ex_equal_ey;
  assign bus.shift_amt   = res_q.shift_amt;
endmodule

// File: tb/tb_exp_align_pipe.sv
// tb/tb_exp_align_pipe.sv - directed self-checking bench for exp_align_pipe (E=8, M=23)
module tb_exp_align_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_align_if bus ();

  exp_align_pipe #(.E(8), .M(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {dif[8:0], e_max[7:0], swap, ex_equal_ey, shift_amt[4:0]}
  function automatic logic [31:0] pk(input logic [8:0] d, input logic [7:0] m,
                                     input logic s, input logic q, input logic [4:0] sh);
    return {8'd0, d, m, s, q, sh};
  endfunction

  function automatic logic [31:0] obs();
    return {8'd0, bus.dif, bus.e_max, bus.swap, bus.ex_equal_ey, bus.shift_amt};
  endfunction

  task automatic send_one(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                          input logic [31:0] exp);
    int n;
    @(posedge clk) #1;
    bus.in_valid  = 1'b1;
    bus.Ex        = ex;
    bus.Ey        = ey;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_res"}, obs(), exp);
  endtask

  logic [7:0]  s_ex [8] = '{8'd50, 8'd40, 8'd200, 8'd7, 8'd1,  8'd128, 8'd255, 8'd3};
  logic [7:0]  s_ey [8] = '{8'd40, 8'd50, 8'd100, 8'd7, 8'd28, 8'd102, 8'd0,   8'd5};
  logic [31:0] s_exp[8];

  initial begin
    int tx, rx, have_hold;
    logic [31:0] hold;

    s_exp[0] = pk(9'd10,  8'd50,  1'b0, 1'b0, 5'd10);
    s_exp[1] = pk(9'd502, 8'd50,  1'b1, 1'b0, 5'd10);
    s_exp[2] = pk(9'd100, 8'd200, 1'b0, 1'b0, 5'd26);
    s_exp[3] = pk(9'd0,   8'd7,   1'b0, 1'b1, 5'd0);
    s_exp[4] = pk(9'd485, 8'd28,  1'b1, 1'b0, 5'd26);
    s_exp[5] = pk(9'd26,  8'd128, 1'b0, 1'b0, 5'd26);
    s_exp[6] = pk(9'd255, 8'd255, 1'b0, 1'b0, 5'd26);
    s_exp[7] = pk(9'd510, 8'd5,   1'b1, 1'b0, 5'd2);

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.Ex        = '0;
    bus.Ey        = '0;
    bus.out_ready = 1'b1;
    #1;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_res", obs(), 32'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);

    send_one("t1", 8'd130, 8'd127, pk(9'd3, 8'd130, 1'b0, 1'b0, 5'd3));
    @(negedge clk);
    check_eq("t1_drain", 32'(bus.out_valid), 32'd0);
    send_one("t2", 8'd0,   8'd255, pk(9'd257, 8'd255, 1'b1, 1'b0, 5'd26));
    send_one("t3", 8'd100, 8'd100, pk(9'd0,   8'd100, 1'b0, 1'b1, 5'd0));
    send_one("t6_26", 8'd126, 8'd100, pk(9'd26, 8'd126, 1'b0, 1'b0, 5'd26));
    send_one("t6_27", 8'd127, 8'd100, pk(9'd27, 8'd127, 1'b0, 1'b0, 5'd26));
    send_one("t6_25", 8'd125, 8'd100, pk(9'd25, 8'd125, 1'b0, 1'b0, 5'd25));
    @(negedge clk);

    // Back-to-back stream with out_ready low for cycles 3..5.
    tx = 0;
    rx = 0;
    have_hold = 0;
    hold = '0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      @(posedge clk) #1;
      bus.in_valid = (tx < 8);
      if (tx < 8) begin
        bus.Ex = s_ex[tx];
        bus.Ey = s_ey[tx];
      end
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        check_eq($sformatf("stream_%0d", rx), obs(), s_exp[rx]);
        rx++;
        have_hold = 0;
      end else if (bus.out_valid) begin
        if (have_hold != 0) check_eq("stall_hold", obs(), hold);
        hold = obs();
        have_hold = 1;
`ifndef EXP_ALIGN_SKID_EN
        check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
`endif
      end
`ifdef EXP_ALIGN_SKID_EN
      if (cyc == 3) check_eq("skid_ready_c3", 32'(bus.in_ready), 32'd1);
      if (cyc == 4) check_eq("skid_ready_c4", 32'(bus.in_ready), 32'd0);
`endif
      if (bus.in_valid && bus.in_ready) tx++;
    end
    check_eq("stream_count", 32'(rx), 32'd8);
    @(posedge clk) #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Reset while a result is held under backpressure.
    @(posedge clk) #1;
    bus.in_valid  = 1'b1;
    bus.Ex        = 8'd60;
    bus.Ey        = 8'd50;
    bus.out_ready = 1'b0;
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_eq("t5_held", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t5_rst_res", obs(), 32'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_post_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t5_post_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check_eq("t5_post_valid2", 32'(bus.out_valid), 32'd0);
    send_one("t5_new", 8'd33, 8'd40, pk(9'd505, 8'd40, 1'b1, 1'b0, 5'd7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
